// File: rtl/matrix_scan_ctrl_if.sv
// Panel-side bundle for matrix_scan_ctrl: scan enable in, pixel index and panel strobes out.
// MATRIX_BRIGHT_EN adds the 3-bit brightness input.
interface matrix_scan_ctrl_if #(
   parameter int unsigned COLS      = 64,
   parameter int unsigned ROWS_HALF = 16
);
   localparam int unsigned ColW = $clog2(COLS);
   localparam int unsigned RowW = $clog2(ROWS_HALF);

   logic            en;
   logic [ColW-1:0] col;
   logic [RowW-1:0] row;
   logic [RowW-1:0] row_addr;
   logic            panel_clk;
   logic            lat;
   logic            oe_n;
   logic            shift;
   logic            frame_done;
`ifdef MATRIX_BRIGHT_EN
   logic [2:0]      brightness;
`endif

   modport master (
`ifdef MATRIX_BRIGHT_EN
      input  brightness,
`endif
      input  en,
      output col, row, row_addr, panel_clk, lat, oe_n, shift, frame_done
   );

   modport slave (
`ifdef MATRIX_BRIGHT_EN
      output brightness,
`endif
      output en,
      input  col, row, row_addr, panel_clk, lat, oe_n, shift, frame_done
   );
endinterface

// File: rtl/matrix_scan_ctrl.sv
// Scan sequencer for the dual-half RGB panel: SHIFT/BLANK/LATCH/DISPLAY per row plus scroll pulse.
// Optional MATRIX_BRIGHT_EN: brightness input trims the DISPLAY oe_n window.
module matrix_scan_ctrl #(
   parameter int unsigned COLS             = 64,
   parameter int unsigned ROWS_HALF        = 16,
   parameter int unsigned OE_HOLD          = 64,
   parameter int unsigned FRAMES_PER_SHIFT = 8
) (
   input logic                clk,
   input logic                rst_n,
   matrix_scan_ctrl_if.master bus
);
   localparam int unsigned ColW    = $clog2(COLS);
   localparam int unsigned RowW    = $clog2(ROWS_HALF);
   localparam int unsigned SpanMax = (2 * COLS > OE_HOLD) ? 2 * COLS : OE_HOLD;
   localparam int unsigned CntW    = $clog2(SpanMax);
   localparam int unsigned FrmW    = (FRAMES_PER_SHIFT > 1) ? $clog2(FRAMES_PER_SHIFT) : 1;

   localparam logic [CntW-1:0] ShiftLast = CntW'(2 * COLS - 1);
   localparam logic [CntW-1:0] HoldLast  = CntW'(OE_HOLD - 1);
   localparam logic [RowW-1:0] RowLast   = RowW'(ROWS_HALF - 1);
   localparam logic [FrmW-1:0] FrmLast   = FrmW'(FRAMES_PER_SHIFT - 1);

   typedef enum logic [2:0] {StIdle, StShift, StBlank, StLatch, StDisplay} state_e;

   state_e          state_q, state_d;
   logic [CntW-1:0] cnt_q, cnt_d;
   logic [RowW-1:0] row_q, row_d;
   logic [RowW-1:0] row_addr_q, row_addr_d;
   logic [FrmW-1:0] frm_q, frm_d;
   logic            valid_q, valid_d;

   logic row_end, frame_end;

   assign row_end   = (state_q == StDisplay) && (cnt_q == HoldLast);
   assign frame_end = row_end && (row_q == RowLast);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= StIdle;
         cnt_q      <= '0;
         row_q      <= '0;
         row_addr_q <= '0;
         frm_q      <= '0;
         valid_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         row_q      <= row_d;
         row_addr_q <= row_addr_d;
         frm_q      <= frm_d;
         valid_q    <= valid_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      row_d      = row_q;
      row_addr_d = row_addr_q;
      frm_d      = frm_q;
      valid_d    = valid_q;
      unique case (state_q)
         StIdle: begin
            if (bus.en) begin
               state_d = StShift;
               cnt_d   = '0;
            end
         end
         // cnt[0] is the panel_clk phase, cnt[ColW:1] the column
         StShift: begin
            if (cnt_q == ShiftLast) begin
               cnt_d   = '0;
               state_d = StBlank;
            end else begin
               cnt_d = cnt_q + CntW'(1);
            end
         end
         StBlank: state_d = StLatch;
         StLatch: begin
            row_addr_d = row_q;
            valid_d    = 1'b1;
            cnt_d      = '0;
            state_d    = StDisplay;
         end
         StDisplay: begin
            if (row_end) begin
               cnt_d   = '0;
               row_d   = (row_q == RowLast) ? '0 : row_q + RowW'(1);
               state_d = bus.en ? StShift : StIdle;
               if (frame_end) frm_d = (frm_q == FrmLast) ? '0 : frm_q + FrmW'(1);
            end else begin
               cnt_d = cnt_q + CntW'(1);
            end
         end
         default: state_d = StIdle;
      endcase
   end

`ifdef MATRIX_BRIGHT_EN
   localparam int unsigned PrdW = CntW + 4;
   logic [PrdW-1:0] on_len;

   always_comb begin
      on_len = ((PrdW'(bus.brightness) + PrdW'(1)) * PrdW'(OE_HOLD)) >> 3;
   end
`endif

   always_comb begin
      bus.col        = '0;
      bus.panel_clk  = 1'b0;
      bus.lat        = 1'b0;
      bus.oe_n       = 1'b1;
      bus.row        = row_q;
      bus.row_addr   = row_addr_q;
      bus.frame_done = frame_end;
      bus.shift      = frame_end && (frm_q == FrmLast);
      unique case (state_q)
         StShift: begin
            bus.col       = cnt_q[ColW:1];
            bus.panel_clk = cnt_q[0];
`ifdef MATRIX_BRIGHT_EN
            bus.oe_n      = 1'b1;
`else
            // keep the previously latched row lit while the next one shifts in
            bus.oe_n      = ~valid_q;
`endif
         end
         StLatch: bus.lat = 1'b1;
         StDisplay: begin
`ifdef MATRIX_BRIGHT_EN
            bus.oe_n = (PrdW'(cnt_q) >= on_len);
`else
            bus.oe_n = 1'b0;
`endif
         end
         default: ;
      endcase
   end
endmodule

// File: tb/tb_matrix_scan_ctrl.sv
// Bench for matrix_scan_ctrl: row-position model checked every cycle plus literal timing pins.
module tb_matrix_scan_ctrl;
   localparam int COLS      = 4;
   localparam int ROWS_HALF = 2;
   localparam int OE_HOLD   = 4;
   localparam int FPS       = 2;
   localparam int P         = 2 * COLS + 2 + OE_HOLD;

   logic clk   = 1'b0;
   logic rst_n = 1'b1;
   bit   cmp_en = 1'b0;
   int   n_checks = 0;
   int   n_fail   = 0;
   int   cyc      = 0;

   matrix_scan_ctrl_if #(.COLS(COLS), .ROWS_HALF(ROWS_HALF)) bus ();

   matrix_scan_ctrl #(
      .COLS(COLS), .ROWS_HALF(ROWS_HALF), .OE_HOLD(OE_HOLD), .FRAMES_PER_SHIFT(FPS)
   ) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (bus)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
      end
   endtask

   // Model: position within the current row period, or not running (idle).
   bit m_run, m_valid;
   int m_pos, m_row, m_row_addr, m_frames;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_run <= 0; m_pos <= 0; m_row <= 0; m_row_addr <= 0; m_frames <= 0; m_valid <= 0;
      end else if (!m_run) begin
         if (bus.en) begin
            m_run <= 1;
            m_pos <= 0;
         end
      end else if (m_pos == P - 1) begin
         m_pos <= 0;
         m_row <= (m_row + 1) % ROWS_HALF;
         if (m_row == ROWS_HALF - 1) m_frames <= (m_frames + 1) % FPS;
         m_run <= bus.en;
      end else begin
         if (m_pos == 2 * COLS + 1) begin
            m_row_addr <= m_row;
            m_valid    <= 1;
         end
         m_pos <= m_pos + 1;
      end
   end

   always @(negedge clk) begin : cmp
      int e_col, e_pclk, e_lat, e_oe, e_fd, e_sh, idx;
      if (rst_n && cmp_en) begin
         e_col = 0; e_pclk = 0; e_lat = 0; e_oe = 1; e_fd = 0; e_sh = 0;
         if (m_run) begin
            if (m_pos < 2 * COLS) begin
               e_col  = m_pos / 2;
               e_pclk = m_pos % 2;
`ifdef MATRIX_BRIGHT_EN
               e_oe   = 1;
`else
               e_oe   = m_valid ? 0 : 1;
`endif
            end else if (m_pos == 2 * COLS + 1) begin
               e_lat = 1;
            end else if (m_pos >= 2 * COLS + 2) begin
               idx  = m_pos - 2 * COLS - 2;
`ifdef MATRIX_BRIGHT_EN
               e_oe = (idx < ((int'(bus.brightness) + 1) * OE_HOLD) / 8) ? 0 : 1;
`else
               e_oe = (idx >= 0) ? 0 : 1;
`endif
            end
            e_fd = (m_pos == P - 1 && m_row == ROWS_HALF - 1) ? 1 : 0;
            e_sh = (e_fd == 1 && m_frames == FPS - 1) ? 1 : 0;
         end
         chk("col", int'(bus.col), e_col);
         chk("row", int'(bus.row), m_row);
         chk("row_addr", int'(bus.row_addr), m_row_addr);
         chk("panel_clk", int'(bus.panel_clk), e_pclk);
         chk("lat", int'(bus.lat), e_lat);
         chk("oe_n", int'(bus.oe_n), e_oe);
         chk("frame_done", int'(bus.frame_done), e_fd);
         chk("shift", int'(bus.shift), e_sh);
         chk("lat_and_pclk", int'(bus.lat & bus.panel_clk), 0);
      end
   end

   // which: 0 lat, 1 frame_done, 2 shift
   task automatic wait_sig(input int which, output int t, output int r);
      bit hit;
      t = -1;
      r = -1;
      for (int k = 0; k < 100; k++) begin
         @(negedge clk);
         hit = (which == 0) ? bus.lat : (which == 1) ? bus.frame_done : bus.shift;
         if (hit) begin
            t = cyc;
            r = int'(bus.row);
            break;
         end
      end
      if (t < 0) chk("pulse_timeout", which, -1);
   endtask

   task automatic wait_lat_row(input int want);
      int t, r;
      for (int k = 0; k < 4; k++) begin
         wait_sig(0, t, r);
         if (r == want) return;
      end
      chk("lat_row_search", r, want);
   endtask

   initial begin : wdog
      #100000;
      $display("FAIL watchdog: simulation did not finish, time %0t required below 100000", $time);
      $fatal(1);
   end

   initial begin : main
      int exp_col[8];
      int exp_pclk[8];
      int t0, t1, t2, t3, r0, r1, r2, r3, f1, f2, s1, s2, dummy;
      exp_col  = '{0, 0, 1, 1, 2, 2, 3, 3};
      exp_pclk = '{0, 1, 0, 1, 0, 1, 0, 1};
      bus.en = 1'b0;
`ifdef MATRIX_BRIGHT_EN
      bus.brightness = 3'd7;
`endif
      #1 rst_n = 1'b0;
      #1;
      chk("rst_col", int'(bus.col), 0);
      chk("rst_row", int'(bus.row), 0);
      chk("rst_row_addr", int'(bus.row_addr), 0);
      chk("rst_panel_clk", int'(bus.panel_clk), 0);
      chk("rst_lat", int'(bus.lat), 0);
      chk("rst_oe_n", int'(bus.oe_n), 1);
      chk("rst_shift", int'(bus.shift), 0);
      chk("rst_frame_done", int'(bus.frame_done), 0);
      @(negedge clk);
      @(negedge clk);
      rst_n  = 1'b1;
      cmp_en = 1'b1;
      repeat (2) @(negedge clk);
      bus.en = 1'b1;

      // First row: shift pattern, blank, latch, display
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         chk("first_col", int'(bus.col), exp_col[i]);
         chk("first_pclk", int'(bus.panel_clk), exp_pclk[i]);
         chk("first_oe_n", int'(bus.oe_n), 1);
      end
      @(negedge clk);
      chk("blank_lat", int'(bus.lat), 0);
      chk("blank_oe_n", int'(bus.oe_n), 1);
      @(negedge clk);
      chk("latch_lat", int'(bus.lat), 1);
      chk("latch_row_addr", int'(bus.row_addr), 0);
      chk("latch_oe_n", int'(bus.oe_n), 1);
      t0 = cyc;
      r0 = int'(bus.row);
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk("first_disp_oe_n", int'(bus.oe_n), 0);
      end

      // Row period and row sequence
      wait_sig(0, t1, r1);
      wait_sig(0, t2, r2);
      wait_sig(0, t3, r3);
      chk("lat_gap1", t1 - t0, 14);
      chk("lat_gap2", t2 - t1, 14);
      chk("lat_gap3", t3 - t2, 14);
      chk("lat_row0", r0, 0);
      chk("lat_row1", r1, 1);
      chk("lat_row2", r2, 0);
      chk("lat_row3", r3, 1);

      // Frame and scroll pulses
      wait_sig(1, f1, dummy);
      wait_sig(1, f2, dummy);
      @(negedge clk);
      chk("fd_width", int'(bus.frame_done), 0);
      chk("fd_gap", f2 - f1, 28);
      wait_sig(2, s1, dummy);
      wait_sig(2, s2, dummy);
      @(negedge clk);
      chk("shift_width", int'(bus.shift), 0);
      chk("shift_gap", s2 - s1, 56);

      // Drop en at cycle 3 of row 1's SHIFT
      wait_lat_row(0);
      repeat (8) @(negedge clk);
      chk("drop_col", int'(bus.col), 1);
      chk("drop_pclk", int'(bus.panel_clk), 1);
      bus.en = 1'b0;
      wait_sig(0, t1, r1);
      chk("drop_lat_row", r1, 1);
      repeat (4) @(negedge clk);
      repeat (6) begin
         @(negedge clk);
         chk("idle_oe_n", int'(bus.oe_n), 1);
         chk("idle_row", int'(bus.row), 0);
      end
      bus.en = 1'b1;
      @(negedge clk);
      @(negedge clk);
      chk("resume_row", int'(bus.row), 0);
      chk("resume_col", int'(bus.col), 0);
      repeat (60) @(negedge clk);

      // Asynchronous reset mid-DISPLAY
      wait_lat_row(1);
      @(negedge clk);
      chk("pre_rst_row_addr", int'(bus.row_addr), 1);
      #2 rst_n = 1'b0;
      #1;
      chk("arst_oe_n", int'(bus.oe_n), 1);
      chk("arst_col", int'(bus.col), 0);
      chk("arst_row", int'(bus.row), 0);
      chk("arst_row_addr", int'(bus.row_addr), 0);
      chk("arst_shift", int'(bus.shift), 0);
      chk("arst_frame_done", int'(bus.frame_done), 0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         chk("post_rst_oe_n", int'(bus.oe_n), 1);
      end

`ifdef MATRIX_BRIGHT_EN
      bus.brightness = 3'd3;
      wait_lat_row(0);
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk("b3_disp_oe_n", int'(bus.oe_n), (i < 2) ? 0 : 1);
      end
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         chk("b3_shift_oe_n", int'(bus.oe_n), 1);
      end
      bus.brightness = 3'd7;
      wait_lat_row(1);
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk("b7_disp_oe_n", int'(bus.oe_n), 0);
      end
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         chk("b7_shift_oe_n", int'(bus.oe_n), 1);
      end
`endif

      repeat (20) @(negedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end
endmodule
